mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Responder end of the request/hit handshake between the datapath request unit and memory. It accepts the instruction request (iREN) and the data requests (dREN/dWEN) and serializes them onto one single-ported RAM interface, with data taking priority. It returns one-cycle ihit/dhit pulses with registered load data. It sits between the request unit/datapath and the RAM model.

Parameters:
ADDR_W, 32, address width of iaddr/daddr/ramaddr
DATA_W, 32, data width of load/store buses
TIMEOUT, 16, max cycles in an access state without ramready before abort (>=1)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, synchronous, active-low
iREN  in  1  instruction read request
iaddr  in  ADDR_W  instruction address
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  ADDR_W  data address
dstore  in  DATA_W  data write value
ihit  out  1  one-cycle instruction completion pulse
iload  out  DATA_W  instruction word, valid when ihit=1, held until next ihit
dhit  out  1  one-cycle data completion pulse
dload  out  DATA_W  data read value, valid when dhit=1 after a read, held until next dhit
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data, valid with ramready
ramready  in  1  RAM access complete this cycle
err  out  1  sticky error flag

Behaviour:
- Single clock CLK; reset synchronous active-low on nRST. Reset state: IDLE. ihit=dhit=0, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0, err=0, timeout counter=0, latched request regs=0.
- States: IDLE, DACC, IACC, DDONE, IDONE.
- IDLE: if dREN|dWEN, latch daddr, dstore and wr=dWEN, then go to DACC. Otherwise if iREN, latch iaddr and go to IACC. Otherwise stay. Data beats instruction when both are present.
- dREN=dWEN=1 in IDLE: treated as a write; err set.
- DACC/IACC: ramaddr=latched addr. ramstore=latched data (DACC only). ramWEN=DACC&wr. ramREN=(DACC&~wr)|IACC. All other states drive ramREN=ramWEN=0.
- Access states ignore input changes; a dropped request does not abort the transaction.
- ramready=1 in DACC: dload<=ramload (reads only; writes leave dload unchanged); go to DDONE. In IACC: iload<=ramload; go to IDONE.
- Counter is cleared on entry to each access state and increments each cycle without ramready. When it reaches TIMEOUT-1 without ramready: abort, set err, load register <=0, go to the DONE state (hit still pulses).
- DDONE: dhit=1 for exactly one cycle, then IDLE. IDONE: ihit=1 for exactly one cycle, then IDLE.
- Latency: request present in cycle 0 (IDLE) → ram enables in cycle 1 → earliest hit in cycle 2 (ramready in cycle 1). The general rule is hit = one cycle after ramready.
- Back-to-back: IDLE lasts at least one cycle between transactions. This lets the request unit mask dREN/dWEN after dhit before re-arbitration.
- Starvation: a continuously asserted data request can delay iREN indefinitely; this is the intended behaviour.
- err: sticky, cleared only by reset.
- Reset mid-access: next state IDLE, enables low the following cycle, no hit pulse, loads cleared.
- ramready outside DACC/IACC: ignored.

Test Plan:
1. Reset then iREN=1, iaddr=0x0000_0040, ramready asserted 1 cycle after ramREN, ramload=0x2008_0001 → ramREN high cycle 1 with ramaddr=0x40; ihit pulses cycle 3; iload=0x2008_0001; dhit stays 0.
2. iREN and dREN both 1 in the same IDLE cycle, daddr=0x100, ramload=0xCAFE_F00D → data access first with dhit=1 and dload=0xCAFE_F00D; iREN still high → IACC begins after one IDLE cycle, followed by ihit.
3. dWEN=1, daddr=0x200, dstore=0x1234_5678, ramready in the same cycle as ramWEN → ramWEN=1, ramstore=0x1234_5678 for one cycle; dhit next cycle; dload unchanged; err=0.
4. TIMEOUT=4, iREN=1, ramready held 0 → ramREN high 4 cycles; ihit pulses; iload=0; err=1 and stays 1 through later good transactions until nRST=0.
5. nRST=0 for one cycle while in DACC → next cycle ramREN=ramWEN=0, state IDLE, no dhit, dload=0.
6. dREN=dWEN=1, daddr=0x300 → write performed (ramWEN=1, ramREN=0); dhit pulses; err=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serializes instruction and data requests onto one single-ported RAM
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready,
    output logic              err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, DACC, IACC, DDONE, IDONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] iload_q, iload_d;
    logic [DATA_W-1:0] dload_q, dload_d;
    logic              err_q, err_d;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            iload_q <= '0;
            dload_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        err_d    = err_q;
        ihit     = 1'b0;
        dhit     = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            IDLE: begin
                // Every access is entered from IDLE, so clearing here covers entry.
                cnt_d = '0;
                if (dREN || dWEN) begin
                    addr_d  = daddr;
                    data_d  = dstore;
                    wr_d    = dWEN;
                    err_d   = err_q | (dREN & dWEN);
                    state_d = DACC;
                end else if (iREN) begin
                    addr_d  = iaddr;
                    state_d = IACC;
                end
            end
            DACC: begin
                ramaddr  = addr_q;
                ramstore = data_q;
                ramWEN   = wr_q;
                ramREN   = ~wr_q;
                if (ramready) begin
                    if (!wr_q) dload_d = ramload;
                    state_d = DDONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    dload_d = '0;
                    state_d = DDONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IACC: begin
                ramaddr = addr_q;
                ramREN  = 1'b1;
                if (ramready) begin
                    iload_d = ramload;
                    state_d = IDONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    iload_d = '0;
                    state_d = IDONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DDONE: begin
                dhit    = 1'b1;
                state_d = IDLE;
            end
            IDONE: begin
                ihit    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign iload = iload_q;
    assign dload = dload_q;
    assign err   = err_q;

endmodule
